// File: rtl/delivery_frame_tx.sv
// delivery_frame_tx: snapshots the visible delivery game state on a start
// pulse and streams it as a byte frame over a valid/ready handshake.
// Frame: HEADER, status {game_over, score, player}, ROWS row bytes
// {objective, obstacle}, and an optional XOR checksum byte.
// Optional feature macro: DELIVERY_FRAME_CHECKSUM_EN (adds the checksum byte).
`timescale 1ns/1ps

module delivery_frame_tx #(
   parameter int          ROWS   = 24,
   parameter logic [7:0]  HEADER = 8'hA5,
   parameter int          CNT_W  = 7
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic [511:0] map_obstacles,
   input  logic [511:0] map_objectives,
   input  logic [3:0]   player_position,
   input  logic [2:0]   pontuacao,
   input  logic         game_over,
   output logic [7:0]   tx_data,
   output logic         tx_valid,
   input  logic         tx_ready,
   output logic         busy,
   output logic         frame_done,
   output logic [7:0]   frames_dropped
);

   localparam int SNAP_W = ROWS * 4;
   localparam int IDX_W  = $clog2(SNAP_W);

   typedef enum logic [2:0] {IDLE, HDR, STAT, ROW, CKS} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  row_idx_q;
   logic [SNAP_W-1:0] obs_snap_q, obj_snap_q;
   logic [3:0]        player_snap_q;
   logic [2:0]        score_snap_q;
   logic              over_snap_q;
   logic              frame_done_q;
   logic [7:0]        drop_cnt_q;

   logic              handshake;
   logic              accept_start;
   logic              last_row;
   logic              final_byte;
   logic [IDX_W-1:0]  bit_idx;

   assign handshake    = tx_valid && tx_ready;
   assign accept_start = start && (state_q == IDLE);
   assign last_row     = (row_idx_q == CNT_W'(ROWS - 1));
   assign bit_idx      = IDX_W'({row_idx_q, 2'b00});

`ifdef DELIVERY_FRAME_CHECKSUM_EN
   logic [7:0] cks_q;

   // Running XOR of every byte already handed to the sink in this frame
   always_ff @(posedge clock) begin
      if (reset)
         cks_q <= 8'h00;
      else if (accept_start)
         cks_q <= 8'h00;
      else if (handshake)
         cks_q <= cks_q ^ tx_data;
   end

   assign final_byte = (state_q == CKS);
`else
   assign final_byte = (state_q == ROW) && last_row;
`endif

   // Map bits beyond the transmitted rows are intentionally ignored
   generate
      if (SNAP_W < 512) begin : g_unused_rows
         logic unused_map_hi;
         assign unused_map_hi = ^{map_obstacles[511:SNAP_W], map_objectives[511:SNAP_W]};
      end
   endgenerate

   // State register
   always_ff @(posedge clock) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Next-state: advance only on a handshake so data holds under backpressure
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = HDR;
         HDR:  if (handshake) state_d = STAT;
         STAT: if (handshake) state_d = ROW;
         ROW: begin
            if (handshake && last_row) begin
`ifdef DELIVERY_FRAME_CHECKSUM_EN
               state_d = CKS;
`else
               state_d = IDLE;
`endif
            end
         end
         CKS:  if (handshake) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode: byte selection driven purely by state and snapshot
   always_comb begin
      tx_data  = 8'h00;
      tx_valid = (state_q != IDLE);
      busy     = (state_q != IDLE);
      case (state_q)
         HDR:  tx_data = HEADER;
         STAT: tx_data = {over_snap_q, score_snap_q, player_snap_q};
         ROW:  tx_data = {obj_snap_q[bit_idx +: 4], obs_snap_q[bit_idx +: 4]};
`ifdef DELIVERY_FRAME_CHECKSUM_EN
         CKS:  tx_data = cks_q;
`endif
         default: tx_data = 8'h00;
      endcase
   end

   // Snapshot capture on an accepted start; row index walks the snapshot
   always_ff @(posedge clock) begin
      if (reset) begin
         obs_snap_q    <= '0;
         obj_snap_q    <= '0;
         player_snap_q <= '0;
         score_snap_q  <= '0;
         over_snap_q   <= 1'b0;
         row_idx_q     <= '0;
      end else begin
         if (accept_start) begin
            obs_snap_q    <= map_obstacles[SNAP_W-1:0];
            obj_snap_q    <= map_objectives[SNAP_W-1:0];
            player_snap_q <= player_position;
            score_snap_q  <= pontuacao;
            over_snap_q   <= game_over;
         end
         if (state_q == STAT && handshake)
            row_idx_q <= '0;
         else if (state_q == ROW && handshake)
            row_idx_q <= row_idx_q + 1'b1;
      end
   end

   // Completion pulse and saturating count of starts ignored while busy
   always_ff @(posedge clock) begin
      if (reset) begin
         frame_done_q <= 1'b0;
         drop_cnt_q   <= 8'h00;
      end else begin
         frame_done_q <= handshake && final_byte;
         if (start && busy && (drop_cnt_q != 8'hFF))
            drop_cnt_q <= drop_cnt_q + 8'h01;
      end
   end

   assign frame_done     = frame_done_q;
   assign frames_dropped = drop_cnt_q;

endmodule

// File: tb/tb_delivery_frame_tx.sv
// tb_delivery_frame_tx: table-driven frames plus hand-written sequences for
// dropped starts, snapshot isolation and reset mid-frame. Expected bytes come
// from a frame model pushed to a scoreboard queue when start is driven.
`timescale 1ns/1ps

module tb_delivery_frame_tx;

   localparam int ROWS = 24;
`ifdef DELIVERY_FRAME_CHECKSUM_EN
   localparam int FLEN = ROWS + 3;
`else
   localparam int FLEN = ROWS + 2;
`endif

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [511:0] map_obstacles = '0;
   logic [511:0] map_objectives = '0;
   logic [3:0]   player_position = '0;
   logic [2:0]   pontuacao = '0;
   logic         game_over = 1'b0;
   logic         tx_ready = 1'b1;
   logic [7:0]   tx_data;
   logic         tx_valid;
   logic         busy;
   logic         frame_done;
   logic [7:0]   frames_dropped;

   delivery_frame_tx #(.ROWS(ROWS), .HEADER(8'hA5), .CNT_W(7)) dut (
      .clock(clock), .reset(reset), .start(start),
      .map_obstacles(map_obstacles), .map_objectives(map_objectives),
      .player_position(player_position), .pontuacao(pontuacao),
      .game_over(game_over), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .busy(busy), .frame_done(frame_done),
      .frames_dropped(frames_dropped)
   );

   always #5 clock = ~clock;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   int         cyc = 0;
   int         expect_done_cyc = -1;
   int         cap_idx = 0;
   int         valid_cnt = 0;
   logic [7:0] cap [0:159];
   logic       stall_prev = 1'b0;
   logic [7:0] data_prev = 8'h00;
   int         ready_mode = 0;
   int         rc = 0;

   typedef struct {
      logic [3:0] obs0, obj0, obs_last;
      logic [3:0] pp;
      logic [2:0] sc;
      logic       go;
      int         bp;
      logic [7:0] exp_status, exp_row0, exp_rowlast, exp_last;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Scoreboard monitor: compares every handshaken byte, holds under stall, done timing
   always @(negedge clock) begin
      cyc++;
      if (!reset) begin
         if (stall_prev) begin
            chk("hold_valid", {31'b0, tx_valid}, 32'd1);
            chk("hold_data", {24'b0, tx_data}, {24'b0, data_prev});
         end
         if (tx_valid) valid_cnt++;
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_byte: got %0h with no byte expected", tx_data);
            end else begin
               chk("byte", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
               if (exp_q.size() == 0) expect_done_cyc = cyc + 1;
            end
            if (cap_idx < 160) cap[cap_idx] = tx_data;
            cap_idx++;
         end
         if (frame_done || (cyc == expect_done_cyc))
            chk("frame_done_timing", {30'b0, frame_done, (cyc == expect_done_cyc)}, 32'd3);
      end
      stall_prev = !reset && tx_valid && !tx_ready;
      data_prev  = tx_data;
   end

   task automatic push_frame();
      logic [7:0] b;
      logic [7:0] x;
      x = 8'h00;
      b = 8'hA5;
      exp_q.push_back(b); x = x ^ b;
      b = {game_over, pontuacao, player_position};
      exp_q.push_back(b); x = x ^ b;
      for (int r = 0; r < ROWS; r++) begin
         b = {map_objectives[r*4 +: 4], map_obstacles[r*4 +: 4]};
         exp_q.push_back(b); x = x ^ b;
      end
`ifdef DELIVERY_FRAME_CHECKSUM_EN
      exp_q.push_back(x);
`endif
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      rc++;
      tx_ready = (ready_mode == 0) ? 1'b1 : ((rc % 3) == 0);
   endtask

   task automatic do_start();
      start = 1'b1;
      push_frame();
      cap_idx = 0;
      valid_cnt = 0;
      rc = 0;
      tx_ready = (ready_mode == 0);
      tick();
      start = 1'b0;
      chk("busy_rise", {31'b0, busy}, 32'd1);
      chk("hdr_valid", {31'b0, tx_valid}, 32'd1);
      chk("hdr_data", {24'b0, tx_data}, 32'hA5);
   endtask

   task automatic wait_done(input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (frame_done) begin
            ok = 1'b1;
            break;
         end
      end
      chk("frame_done_seen", {31'b0, ok}, 32'd1);
      chk("idle_valid", {31'b0, tx_valid}, 32'd0);
      chk("idle_busy", {31'b0, busy}, 32'd0);
      chk("queue_empty", exp_q.size(), 32'd0);
      chk("frame_len", cap_idx, FLEN);
   endtask

   vec_t vecs [4];

   initial begin
`ifdef DELIVERY_FRAME_CHECKSUM_EN
      vecs[0] = '{4'h0, 4'h0, 4'h0, 4'b1000, 3'd3, 1'b0, 0, 8'h38, 8'h00, 8'h00, 8'h9D};
      vecs[1] = '{4'h2, 4'h4, 4'hF, 4'b1000, 3'd3, 1'b0, 0, 8'h38, 8'h42, 8'h0F, 8'hD0};
      vecs[2] = '{4'h0, 4'h0, 4'h0, 4'b1000, 3'd3, 1'b0, 1, 8'h38, 8'h00, 8'h00, 8'h9D};
      vecs[3] = '{4'hF, 4'hF, 4'h0, 4'b0100, 3'd7, 1'b1, 0, 8'hF4, 8'hFF, 8'h00, 8'hAE};
`else
      vecs[0] = '{4'h0, 4'h0, 4'h0, 4'b1000, 3'd3, 1'b0, 0, 8'h38, 8'h00, 8'h00, 8'h00};
      vecs[1] = '{4'h2, 4'h4, 4'hF, 4'b1000, 3'd3, 1'b0, 0, 8'h38, 8'h42, 8'h0F, 8'h0F};
      vecs[2] = '{4'h0, 4'h0, 4'h0, 4'b1000, 3'd3, 1'b0, 1, 8'h38, 8'h00, 8'h00, 8'h00};
      vecs[3] = '{4'hF, 4'hF, 4'h0, 4'b0100, 3'd7, 1'b1, 0, 8'hF4, 8'hFF, 8'h00, 8'h00};
`endif

      reset = 1'b1;
      repeat (3) tick();
      chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
      chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
      chk("rst_dropped", {24'b0, frames_dropped}, 32'd0);
      reset = 1'b0;
      tick();

      for (int v = 0; v < 4; v++) begin
         ready_mode      = vecs[v].bp;
         map_obstacles   = '0;
         map_objectives  = '0;
         map_obstacles[3:0] = vecs[v].obs0;
         map_objectives[3:0] = vecs[v].obj0;
         map_obstacles[(ROWS-1)*4 +: 4] = vecs[v].obs_last;
         map_obstacles[ROWS*4] = 1'b1;
         player_position = vecs[v].pp;
         pontuacao       = vecs[v].sc;
         game_over       = vecs[v].go;
         do_start();
         wait_done(400);
         chk("status_byte", {24'b0, cap[1]}, {24'b0, vecs[v].exp_status});
         chk("row0_byte", {24'b0, cap[2]}, {24'b0, vecs[v].exp_row0});
         chk("rowlast_byte", {24'b0, cap[ROWS+1]}, {24'b0, vecs[v].exp_rowlast});
         chk("final_byte", {24'b0, cap[FLEN-1]}, {24'b0, vecs[v].exp_last});
         chk("valid_cycles", valid_cnt, (vecs[v].bp != 0) ? 3 * FLEN : FLEN);
         tick();
         tick();
      end

      // Snapshot isolation and dropped starts
      ready_mode      = 0;
      map_obstacles   = '0;
      map_objectives  = '0;
      player_position = 4'b1000;
      pontuacao       = 3'd3;
      game_over       = 1'b0;
      do_start();
      repeat (3) tick();
      player_position = 4'b0001;
      map_obstacles   = '1;
      for (int k = 0; k < 3; k++) begin
         start = 1'b1;
         tick();
         start = 1'b0;
         tick();
      end
      chk("busy_mid", {31'b0, busy}, 32'd1);
      wait_done(400);
      chk("snap_status", {24'b0, cap[1]}, 32'h38);
      chk("dropped_3", {24'b0, frames_dropped}, 32'd3);

      // Start in the frame_done cycle, then reset after the fifth byte
      do_start();
      for (int i = 0; i < 50; i++) begin
         if (cap_idx >= 5) break;
         tick();
      end
      chk("reached_5_bytes", {31'b0, (cap_idx >= 5)}, 32'd1);
      chk("chained_status", {24'b0, cap[1]}, 32'h31);
      reset = 1'b1;
      exp_q.delete();
      expect_done_cyc = -1;
      tick();
      chk("mid_rst_valid", {31'b0, tx_valid}, 32'd0);
      chk("mid_rst_busy", {31'b0, busy}, 32'd0);
      chk("mid_rst_dropped", {24'b0, frames_dropped}, 32'd0);
      chk("mid_rst_done", {31'b0, frame_done}, 32'd0);
      reset = 1'b0;
      repeat (4) tick();
      chk("no_done_after_abort", {31'b0, frame_done}, 32'd0);

      do_start();
      wait_done(400);
      chk("fresh_header", {24'b0, cap[0]}, 32'hA5);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
